// File: rtl/scan_sel_gen_pkg.sv
// Shared types and constants for the scan select generator.
package scan_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_e;

   localparam int unsigned CH_NUM = 16;
   localparam int unsigned SEL_W  = 4;

   localparam logic MODE_CONT   = 1'b0;
   localparam logic MODE_SINGLE = 1'b1;

endpackage

// File: rtl/scan_sel_gen_if.sv
// Control/status bundle between a scan controller and scan_sel_gen.
// skip_mask exists only when SCAN_SKIP_MASK_EN is defined.
interface scan_sel_gen_if
   import scan_pkg::*;
#(
   parameter int unsigned DWELL_W = 8
);
   logic               start;
   logic               stop;
   logic               mode;
   logic [DWELL_W-1:0] dwell;
`ifdef SCAN_SKIP_MASK_EN
   logic [CH_NUM-1:0]  skip_mask;
`endif
   logic [SEL_W-1:0]   sel;
   logic               en;
   logic               busy;
   logic               done;
   logic               wrap;

   modport master (
      output start, stop, mode, dwell,
`ifdef SCAN_SKIP_MASK_EN
      output skip_mask,
`endif
      input  sel, en, busy, done, wrap
   );

   modport slave (
      input  start, stop, mode, dwell,
`ifdef SCAN_SKIP_MASK_EN
      input  skip_mask,
`endif
      output sel, en, busy, done, wrap
   );
endinterface

// File: rtl/scan_sel_gen_next_idx.sv
// Combinational finder for the next/lowest unmasked channel.
// Built only when SCAN_SKIP_MASK_EN is defined.
`ifdef SCAN_SKIP_MASK_EN
module scan_next_idx
   import scan_pkg::*;
(
   input  logic [CH_NUM-1:0] mask_i,
   input  logic [SEL_W-1:0]  sel_i,
   output logic [SEL_W-1:0]  next_o,
   output logic              found_o,
   output logic [SEL_W-1:0]  lowest_o
);

   always_comb begin
      next_o   = '0;
      found_o  = 1'b0;
      lowest_o = '0;
      for (int unsigned i = 0; i < CH_NUM; i++) begin
         if (!found_o && (i > 32'(sel_i)) && !mask_i[i]) begin
            found_o = 1'b1;
            next_o  = SEL_W'(i);
         end
      end
      // Scan downward so the last hit is the lowest unmasked index.
      for (int unsigned j = CH_NUM; j > 0; j--) begin
         if (!mask_i[j-1]) begin
            lowest_o = SEL_W'(j - 1);
         end
      end
   end

endmodule
`endif

// File: rtl/scan_sel_gen.sv
// Sequential select/enable generator feeding a 4-to-16 decoder.
// Optional channel skipping is enabled by defining SCAN_SKIP_MASK_EN.
module scan_sel_gen
   import scan_pkg::*;
#(
   parameter int unsigned DWELL_W = 8
)(
   input  logic           clk,
   input  logic           rst,
   scan_sel_gen_if.slave  bus
);

   state_e             state_q, state_d;
   logic [SEL_W-1:0]   sel_q, sel_d;
   logic               en_q, en_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               wrap_q, wrap_d;
   logic [DWELL_W-1:0] cnt_q, cnt_d;
   logic               mode_q, mode_d;
   logic [DWELL_W-1:0] dwell_q, dwell_d;

   logic               has_next;
   logic [SEL_W-1:0]   next_idx;
   logic [SEL_W-1:0]   first_idx;
   logic               all_masked;

`ifdef SCAN_SKIP_MASK_EN
   logic [CH_NUM-1:0]  mask_q, mask_d;
   logic [CH_NUM-1:0]  mask_cur;

   // In IDLE the finder looks at the live mask so the start channel is known.
   assign mask_cur   = (state_q == IDLE) ? bus.skip_mask : mask_q;
   assign all_masked = &bus.skip_mask;

   scan_next_idx u_next_idx (
      .mask_i   (mask_cur),
      .sel_i    (sel_q),
      .next_o   (next_idx),
      .found_o  (has_next),
      .lowest_o (first_idx)
   );
`else
   assign has_next   = (sel_q != SEL_W'(CH_NUM - 1));
   assign next_idx   = sel_q + SEL_W'(1);
   assign first_idx  = '0;
   assign all_masked = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      en_d    = en_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      wrap_d  = 1'b0;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      dwell_d = dwell_q;
`ifdef SCAN_SKIP_MASK_EN
      mask_d  = mask_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (bus.start && !bus.stop) begin
               if (all_masked) begin
                  done_d = 1'b1;
               end else begin
                  state_d = SCAN;
                  sel_d   = first_idx;
                  en_d    = 1'b1;
                  busy_d  = 1'b1;
                  cnt_d   = '0;
                  mode_d  = bus.mode;
                  dwell_d = bus.dwell;
`ifdef SCAN_SKIP_MASK_EN
                  mask_d  = bus.skip_mask;
`endif
               end
            end
         end
         SCAN: begin
            if (bus.stop) begin
               state_d = IDLE;
               sel_d   = '0;
               en_d    = 1'b0;
               busy_d  = 1'b0;
               cnt_d   = '0;
            end else if (cnt_q != dwell_q) begin
               cnt_d = cnt_q + DWELL_W'(1);
            end else begin
               cnt_d = '0;
               if (has_next) begin
                  sel_d = next_idx;
               end else if (mode_q == MODE_CONT) begin
                  sel_d  = first_idx;
                  wrap_d = 1'b1;
               end else begin
                  state_d = IDLE;
                  sel_d   = '0;
                  en_d    = 1'b0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         sel_q   <= '0;
         en_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         wrap_q  <= 1'b0;
         cnt_q   <= '0;
         mode_q  <= 1'b0;
         dwell_q <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         en_q    <= en_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         wrap_q  <= wrap_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
         dwell_q <= dwell_d;
      end
   end

`ifdef SCAN_SKIP_MASK_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mask_q <= '0;
      end else begin
         mask_q <= mask_d;
      end
   end
`endif

   assign bus.sel  = sel_q;
   assign bus.en   = en_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_scan_sel_gen.sv
// Self-checking bench for scan_sel_gen; per-cycle expectations come from a
// behavioural channel-sweep model and are queued, then popped at negedge.
module tb_scan_sel_gen;
   import scan_pkg::*;

   localparam int unsigned DW = 8;

   logic clk;
   logic rst;

   scan_sel_gen_if #(.DWELL_W(DW)) bus ();

   scan_sel_gen #(.DWELL_W(DW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned checks = 0;
   int unsigned errors = 0;

   logic [7:0] exp_q[$];

   // model state
   bit         m_scan;
   int         m_sel;
   bit         m_en, m_busy, m_done, m_wrap;
   int         m_cnt, m_dwell;
   bit         m_mode;
   logic [15:0] m_mask;

   int unsigned en_cycles, done_pulses, wrap_pulses;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic int lowest_free(input logic [15:0] m);
      for (int k = 0; k < 16; k++) if (!m[k]) return k;
      return -1;
   endfunction

   function automatic int next_free(input logic [15:0] m, input int s);
      for (int k = s + 1; k < 16; k++) if (!m[k]) return k;
      return -1;
   endfunction

   function automatic logic [15:0] live_mask();
`ifdef SCAN_SKIP_MASK_EN
      return bus.skip_mask;
`else
      return 16'h0000;
`endif
   endfunction

   task automatic model_reset();
      m_scan = 0; m_sel = 0; m_en = 0; m_busy = 0; m_done = 0; m_wrap = 0;
      m_cnt = 0; m_dwell = 0; m_mode = 0; m_mask = '0;
   endtask

   task automatic model_clock();
      int f, n;
      m_done = 0;
      m_wrap = 0;
      if (!m_scan) begin
         if (bus.start && !bus.stop) begin
            f = lowest_free(live_mask());
            if (f < 0) begin
               m_done = 1;
            end else begin
               m_scan = 1; m_sel = f; m_en = 1; m_busy = 1; m_cnt = 0;
               m_mode = bus.mode; m_dwell = int'(bus.dwell); m_mask = live_mask();
            end
         end
      end else if (bus.stop) begin
         m_scan = 0; m_sel = 0; m_en = 0; m_busy = 0; m_cnt = 0;
      end else if (m_cnt < m_dwell) begin
         m_cnt++;
      end else begin
         m_cnt = 0;
         n = next_free(m_mask, m_sel);
         if (n >= 0) begin
            m_sel = n;
         end else if (m_mode == MODE_CONT) begin
            m_sel = lowest_free(m_mask);
            m_wrap = 1;
         end else begin
            m_scan = 0; m_sel = 0; m_en = 0; m_busy = 0; m_done = 1;
         end
      end
   endtask

   function automatic logic [7:0] observed();
      return {bus.sel, bus.en, bus.busy, bus.done, bus.wrap};
   endfunction

   task automatic step();
      @(posedge clk);
      model_clock();
      exp_q.push_back({4'(m_sel), m_en, m_busy, m_done, m_wrap});
      @(negedge clk);
      check("cycle", 32'(observed()), 32'(exp_q.pop_front()));
      if (bus.en)   en_cycles++;
      if (bus.done) done_pulses++;
      if (bus.wrap) wrap_pulses++;
   endtask

   task automatic clear_counts();
      en_cycles = 0; done_pulses = 0; wrap_pulses = 0;
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
   endtask

   initial begin
      bit seen9;
      rst = 1'b1;
      bus.start = 1'b0; bus.stop = 1'b0; bus.mode = MODE_CONT; bus.dwell = '0;
`ifdef SCAN_SKIP_MASK_EN
      bus.skip_mask = '0;
`endif
      model_reset();
      clear_counts();
      #1;
      check("reset_out", 32'(observed()), 32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // idle after reset
      repeat (50) step();

      // single pass, dwell=2; mid-scan dwell/mode changes and a re-start are ignored
      bus.mode = MODE_SINGLE; bus.dwell = 8'd2;
      clear_counts();
      pulse_start();
      repeat (10) step();
      bus.dwell = 8'd7; bus.mode = MODE_CONT;
      repeat (5) step();
      pulse_start();
      repeat (40) step();
      check("single_en_cycles", en_cycles, 48);
      check("single_done", done_pulses, 1);
      check("single_busy_after", 32'(bus.busy), 0);

      // continuous, dwell=0, wraps every 16 cycles
      bus.mode = MODE_CONT; bus.dwell = 8'd0;
      pulse_start();
      clear_counts();
      repeat (40) step();
      check("cont_wraps", wrap_pulses, 2);
      seen9 = 0;
      for (int i = 0; i < 32 && !seen9; i++) begin
         if (bus.sel == 4'd9) seen9 = 1; else step();
      end
      check("wait_sel9", 32'(seen9), 1);
      clear_counts();
      bus.stop = 1'b1;
      step();
      bus.stop = 1'b0;
      check("stop_sel", 32'(bus.sel), 0);
      check("stop_en", 32'(bus.en), 0);
      repeat (5) step();
      check("stop_no_done", done_pulses, 0);

      // start and stop together in IDLE
      bus.start = 1'b1; bus.stop = 1'b1;
      repeat (3) step();
      bus.start = 1'b0; bus.stop = 1'b0;
      check("start_stop_idle", 32'(bus.busy), 0);

      // async reset mid-dwell
      bus.dwell = 8'd5;
      pulse_start();
      repeat (10) step();
      #1 rst = 1'b1;
      #1 check("async_rst", 32'(observed()), 32'h0);
      #1 rst = 1'b0;
      model_reset();
      repeat (5) step();

      // max dwell, continuous, then stop
      bus.dwell = 8'hFF; bus.mode = MODE_CONT;
      pulse_start();
      repeat (600) step();
      bus.stop = 1'b1;
      step();
      bus.stop = 1'b0;
      repeat (3) step();

`ifdef SCAN_SKIP_MASK_EN
      bus.skip_mask = 16'h00F0; bus.dwell = 8'd0; bus.mode = MODE_SINGLE;
      clear_counts();
      pulse_start();
      repeat (20) step();
      check("mask_en_cycles", en_cycles, 12);
      check("mask_done", done_pulses, 1);

      bus.skip_mask = 16'hFFFF;
      clear_counts();
      pulse_start();
      repeat (5) step();
      check("allmask_done", done_pulses, 1);
      check("allmask_en", en_cycles, 0);
      bus.skip_mask = '0;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish, got running expected finished");
      $fatal(1);
   end

endmodule
